// File: rtl/hdmi_cfg_pkg.sv
// Shared types and constants for the HDMI transmitter
// power-up configuration sequencer.
package hdmi_cfg_pkg;

  localparam int REG_W = 8;
  localparam int DAT_W = 8;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } cfg_state_e;

  typedef struct packed {
    logic [REG_W-1:0] reg_a;
    logic [DAT_W-1:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/hdmi_cfg_sequencer_if.sv
// Control and i2c-engine request bundle between the
// sequencer and its surroundings.
interface hdmi_cfg_sequencer_if;
  import hdmi_cfg_pkg::*;

  logic             cfg_start;
  logic             i2c_start;
  logic [6:0]       i2c_dev_addr;
  logic [REG_W-1:0] i2c_reg_addr;
  logic [DAT_W-1:0] i2c_wr_data;
  logic             i2c_busy;
  logic             i2c_ack_err;
  logic             cfg_active;
  logic             cfg_done;
  logic             cfg_error;
  logic [7:0]       err_index;

  modport master (
    input  cfg_start,
    input  i2c_busy,
    input  i2c_ack_err,
    output i2c_start,
    output i2c_dev_addr,
    output i2c_reg_addr,
    output i2c_wr_data,
    output cfg_active,
    output cfg_done,
    output cfg_error,
    output err_index
  );

  modport slave (
    output cfg_start,
    output i2c_busy,
    output i2c_ack_err,
    input  i2c_start,
    input  i2c_dev_addr,
    input  i2c_reg_addr,
    input  i2c_wr_data,
    input  cfg_active,
    input  cfg_done,
    input  cfg_error,
    input  err_index
  );

endinterface

// File: rtl/hdmi_cfg_rom.sv
// Transmitter power-up register table, idx -> {reg, data}.
// Indices at or beyond NUM_REGS read as zero.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [7:0] idx_i,
  output cfg_entry_t entry_o
);

  cfg_entry_t raw;

  always_comb begin
    raw = '0;
    case (idx_i)
      8'd0:    raw = {8'h41, 8'h10};
      8'd1:    raw = {8'h98, 8'h03};
      8'd2:    raw = {8'h9A, 8'hE0};
      8'd3:    raw = {8'h9C, 8'h30};
      8'd4:    raw = {8'h9D, 8'h61};
      8'd5:    raw = {8'hA2, 8'hA4};
      8'd6:    raw = {8'hA3, 8'hA4};
      8'd7:    raw = {8'hE0, 8'hD0};
      8'd8:    raw = {8'hF9, 8'h00};
      8'd9:    raw = {8'h15, 8'h00};
      8'd10:   raw = {8'h16, 8'h30};
      8'd11:   raw = {8'h18, 8'h46};
      8'd12:   raw = {8'hAF, 8'h04};
      8'd13:   raw = {8'h40, 8'h80};
      8'd14:   raw = {8'hD6, 8'hC0};
      8'd15:   raw = {8'h55, 8'h00};
      default: raw = '0;
    endcase
    entry_o = (32'(idx_i) < NUM_REGS) ? raw : '0;
  end

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// Walks the power-up table issuing one i2c write per entry,
// with bounded retry on NACK or handshake timeout.
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int          NUM_REGS     = 16,
  parameter logic [6:0]  DEV_ADDR     = DEV_ADDR_DEF,
  parameter logic [15:0] PWR_WAIT     = 16'd200,
  parameter int          RETRY_MAX    = 3,
  parameter logic [15:0] BUSY_TIMEOUT = 16'd4000
) (
  input logic clk,
  input logic rst_n,
  hdmi_cfg_sequencer_if.master bus
);

  cfg_state_e  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [2:0]  retry_q, retry_d;
  logic [15:0] timer_q, timer_d;

  cfg_entry_t entry;
  logic       last_idx;
  logic       pwr_exp;
  logic       bus_exp;
  logic       can_retry;
  logic       retry_req;
  logic       xfer;

  hdmi_cfg_rom #(
    .NUM_REGS (NUM_REGS)
  ) u_rom (
    .idx_i   (idx_q),
    .entry_o (entry)
  );

  assign last_idx  = (32'(idx_q) == NUM_REGS - 1);
  assign pwr_exp   = ({1'b0, timer_q} + 17'd1) >= {1'b0, PWR_WAIT};
  assign bus_exp   = ({1'b0, timer_q} + 17'd1) >= {1'b0, BUSY_TIMEOUT};
  assign can_retry = (32'(retry_q) < RETRY_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    retry_req = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.cfg_start) begin
          state_d = ST_PWR_WAIT;
          idx_d   = '0;
          retry_d = '0;
          timer_d = '0;
        end
      end
      ST_PWR_WAIT: begin
        if (pwr_exp) state_d = ST_ISSUE;
        else timer_d = timer_q + 16'd1;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_HI;
        timer_d = '0;
      end
      ST_WAIT_HI: begin
        if (bus.i2c_busy) begin
          state_d = ST_WAIT_LO;
          timer_d = '0;
        end else if (bus_exp) begin
          retry_req = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.i2c_busy) begin
          if (bus.i2c_ack_err) retry_req = 1'b1;
          else state_d = ST_NEXT;
        end else if (bus_exp) begin
          retry_req = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_NEXT: begin
        retry_d = '0;
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Retry re-issues the same idx; exhaustion parks in FAIL holding idx.
    if (retry_req) begin
      if (can_retry) begin
        retry_d = retry_q + 3'd1;
        state_d = ST_ISSUE;
      end else begin
        state_d = ST_FAIL;
      end
    end
  end

  assign xfer = (state_q == ST_ISSUE) ||
                (state_q == ST_WAIT_HI) ||
                (state_q == ST_WAIT_LO);

  assign bus.i2c_start    = (state_q == ST_ISSUE);
  assign bus.i2c_dev_addr = DEV_ADDR;
  assign bus.i2c_reg_addr = xfer ? entry.reg_a : '0;
  assign bus.i2c_wr_data  = xfer ? entry.data : '0;
  assign bus.cfg_active   = (state_q != ST_IDLE) &&
                            (state_q != ST_DONE) &&
                            (state_q != ST_FAIL);
  assign bus.cfg_done     = (state_q == ST_DONE);
  assign bus.cfg_error    = (state_q == ST_FAIL);
  assign bus.err_index    = (state_q == ST_FAIL) ? idx_q : '0;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Directed bench: table of NACK scenarios plus hand-written
// timeout, restart and mid-run reset sequences.
module tb_hdmi_cfg_sequencer;

  localparam int BUSY_CYC = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a;
  logic ack_a;

  int n_cmp = 0;
  int n_bad = 0;

  int nack_entry = -1;
  int nack_limit = 0;
  int exp_idx;
  int att;
  int cnt;
  logic cur_nack;

  logic [7:0] q_reg[$];
  logic [7:0] q_dat[$];
  int         q_idx[$];

  logic [7:0] exp_reg [4];
  logic [7:0] exp_dat [4];

  typedef struct {
    int   ne;
    int   nl;
    int   np;
    logic done;
    logic err;
    int   eidx;
  } vec_t;

  vec_t vt [5];

  hdmi_cfg_sequencer_if ia ();
  hdmi_cfg_sequencer_if ib ();

  assign ia.cfg_start   = start_a;
  assign ia.i2c_busy    = busy_a;
  assign ia.i2c_ack_err = ack_a;
  assign ib.cfg_start   = start_b;
  assign ib.i2c_busy    = 1'b0;
  assign ib.i2c_ack_err = 1'b0;

  hdmi_cfg_sequencer #(
    .NUM_REGS     (4),
    .DEV_ADDR     (7'h39),
    .PWR_WAIT     (16'd5),
    .RETRY_MAX    (3),
    .BUSY_TIMEOUT (16'd50)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  hdmi_cfg_sequencer #(
    .NUM_REGS     (4),
    .DEV_ADDR     (7'h39),
    .PWR_WAIT     (16'd5),
    .RETRY_MAX    (0),
    .BUSY_TIMEOUT (16'd50)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  always #5 clk = ~clk;

  // Engine model: busy for BUSY_CYC cycles, NACK per policy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_a   <= 1'b0;
      ack_a    <= 1'b0;
      cnt      <= 0;
      exp_idx  <= 0;
      att      <= 0;
      cur_nack <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      if (ia.cfg_start && !ia.cfg_active) begin
        exp_idx <= 0;
        att     <= 0;
      end
      if (ia.i2c_start) begin
        busy_a   <= 1'b1;
        cnt      <= BUSY_CYC - 1;
        cur_nack <= (exp_idx == nack_entry) && (att < nack_limit);
        att      <= att + 1;
      end else if (busy_a) begin
        if (cnt == 0) begin
          busy_a <= 1'b0;
          ack_a  <= cur_nack;
          if (!cur_nack) begin
            exp_idx <= exp_idx + 1;
            att     <= 0;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ia.i2c_start) begin
      q_reg.push_back(ia.i2c_reg_addr);
      q_dat.push_back(ia.i2c_wr_data);
      q_idx.push_back(exp_idx);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_pulses(input int from);
    int j;
    for (int i = from; i < q_reg.size(); i++) begin
      j = q_idx[i] % 4;
      chk($sformatf("pulse%0d_reg", i), 32'(q_reg[i]), 32'(exp_reg[j]));
      chk($sformatf("pulse%0d_dat", i), 32'(q_dat[i]), 32'(exp_dat[j]));
    end
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (ia.cfg_active && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait_bound", 32'(k < 3000), 32'd1);
  endtask

  task automatic run_a(output int lat, output int np);
    int p0;
    int k;
    p0  = q_reg.size();
    lat = -1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 1;
    while (ia.cfg_active && k < 3000) begin
      if (ia.i2c_start && lat < 0) lat = k;
      @(negedge clk);
      k++;
    end
    chk("run_bound", 32'(k < 3000), 32'd1);
    np = q_reg.size() - p0;
    check_pulses(p0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, 32'(ia.i2c_start), 32'd0);
    chk({tag, "_dev"}, 32'(ia.i2c_dev_addr), 32'h39);
    chk({tag, "_reg"}, 32'(ia.i2c_reg_addr), 32'd0);
    chk({tag, "_dat"}, 32'(ia.i2c_wr_data), 32'd0);
    chk({tag, "_active"}, 32'(ia.cfg_active), 32'd0);
    chk({tag, "_done"}, 32'(ia.cfg_done), 32'd0);
    chk({tag, "_error"}, 32'(ia.cfg_error), 32'd0);
    chk({tag, "_eidx"}, 32'(ia.err_index), 32'd0);
  endtask

  initial begin
    int lat;
    int np;
    int k;
    int n;
    int p0;
    int extra;

    exp_reg = '{8'h41, 8'h98, 8'h9A, 8'h9C};
    exp_dat = '{8'h10, 8'h03, 8'hE0, 8'h30};

    vt[0] = '{-1, 0, 4, 1'b1, 1'b0, 0};
    vt[1] = '{2, 1, 5, 1'b1, 1'b0, 0};
    vt[2] = '{1, 99, 5, 1'b0, 1'b1, 1};
    vt[3] = '{0, 3, 7, 1'b1, 1'b0, 0};
    vt[4] = '{3, 99, 7, 1'b0, 1'b1, 3};

    #1;
    chk_reset_outs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_active", 32'(ia.cfg_active), 32'd0);

    for (int i = 0; i < 5; i++) begin
      nack_entry = vt[i].ne;
      nack_limit = vt[i].nl;
      run_a(lat, np);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd6);
      chk($sformatf("v%0d_pulses", i), 32'(np), 32'(vt[i].np));
      chk($sformatf("v%0d_done", i), 32'(ia.cfg_done), 32'(vt[i].done));
      chk($sformatf("v%0d_err", i), 32'(ia.cfg_error), 32'(vt[i].err));
      chk($sformatf("v%0d_eidx", i), 32'(ia.err_index), 32'(vt[i].eidx));
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_quiet", i), 32'(q_reg.size()), 32'(q_reg.size() - np + vt[i].np));
    end

    // Handshake timeout: engine B never raises busy.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (!ib.i2c_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_pulse", 32'(ib.i2c_start), 32'd1);
    chk("tmo_reg", 32'(ib.i2c_reg_addr), 32'h41);
    n = 0;
    extra = 0;
    while (!ib.cfg_error && n < 200) begin
      @(negedge clk);
      n++;
      if (ib.i2c_start) extra++;
    end
    chk("tmo_latency", 32'(n >= 50 && n <= 51), 32'd1);
    chk("tmo_extra", 32'(extra), 32'd0);
    chk("tmo_eidx", 32'(ib.err_index), 32'd0);
    chk("tmo_done", 32'(ib.cfg_done), 32'd0);
    chk("tmo_active", 32'(ib.cfg_active), 32'd0);

    // Start while active is ignored; a later start reruns.
    nack_entry = -1;
    p0 = q_reg.size();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (40) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle(k);
    chk("swa_pulses", 32'(q_reg.size() - p0), 32'd4);
    chk("swa_done", 32'(ia.cfg_done), 32'd1);
    check_pulses(p0);
    p0 = q_reg.size();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("swa_done_clr", 32'(ia.cfg_done), 32'd0);
    chk("swa_rearm", 32'(ia.cfg_active), 32'd1);
    wait_idle(k);
    chk("swa2_pulses", 32'(q_reg.size() - p0), 32'd4);
    chk("swa2_done", 32'(ia.cfg_done), 32'd1);
    check_pulses(p0);

    // Reset during WAIT_LO of entry 2.
    p0 = q_reg.size();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (q_reg.size() < p0 + 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("mid_third_pulse", 32'(q_reg.size() - p0), 32'd3);
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(ia.i2c_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = q_reg.size();
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 32'(ia.cfg_active), 32'd0);
    chk("post_rst_quiet", 32'(q_reg.size() - p0), 32'd0);
    run_a(lat, np);
    chk("rerun_lat", 32'(lat), 32'd6);
    chk("rerun_pulses", 32'(np), 32'd4);
    chk("rerun_first_reg", 32'(q_reg[p0]), 32'h41);
    chk("rerun_done", 32'(ia.cfg_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
